mult_unit_mips: RTL and testbench
=================================

MULT_UNIT_MIPS -- requirements
Module: mult_unit_mips

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  Mult control from the decode stage; request a multiply.
- op_a  input  32  multiplicand (rs value).
- op_b  input  32  multiplier (rt value).
- is_signed  input  1  1 = signed mult, 0 = multu. Ignored unless MULT_SIGNED_EN is defined.
- busy  output  1  unit is in RUN or DONE.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  32  upper 32 bits of the last product.
- lo  output  32  lower 32 bits of the last product.
REQ-002 SHALL have parameter WIDTH, default 32, giving the operand width; hi and lo are WIDTH bits each.

Function
REQ-003 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1, SHALL latch op_a, op_b and is_signed, clear the accumulator and counter, and go to RUN on the next edge.
REQ-005 In RUN, SHALL perform one shift-add step per cycle:
- add the multiplicand to the accumulator upper half when the multiplier LSB is 1;
- then shift the {accumulator, multiplier} pair right by one.
REQ-006 SHALL stay in RUN for exactly WIDTH cycles, counted by a counter from 0 to WIDTH-1, then go to DONE.
- No early exit: zero operands still take WIDTH cycles.
REQ-007 In DONE, SHALL load hi/lo with the 2*WIDTH-bit product, assert done for that one cycle, and return to IDLE.
REQ-008 Latency: start sampled at edge N gives done=1 and the new hi/lo in the cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-009 SHALL hold hi/lo unchanged outside DONE; the previous result stays readable during RUN.
REQ-010 stall SHALL equal (state==IDLE & start) | (state==RUN), and is combinational.
- In DONE, stall=0 so the held instruction can retire.
REQ-011 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-012 SHALL ignore start while busy=1; no queuing and no restart.
REQ-013 start in the cycle immediately after DONE (back in IDLE) SHALL be accepted normally.
REQ-014 Unsigned product SHALL be exact modulo 2^(2*WIDTH); the accumulator SHALL be WIDTH+1 bits so the carry is not lost.

Reset
REQ-015 While rst_n=0, the block SHALL:
- force IDLE;
- clear the counter, accumulator and operand registers;
- drive hi=0, lo=0, done=0, busy=0 and stall=0.
REQ-016 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows and hi/lo read 0.
REQ-017 After rst_n deasserts, the first rising edge with start=1 in IDLE SHALL start a new operation.

Configuration
REQ-018 When MULT_SIGNED_EN is defined:
- with is_signed=1, SHALL multiply the operand magnitudes;
- SHALL two's-complement negate the 2*WIDTH product in DONE when the operand signs differ.
- Latency is unchanged.
REQ-019 When MULT_SIGNED_EN is undefined, SHALL ignore is_signed and always compute the unsigned product; no negation logic is built.

Structure
REQ-020 SHALL place the state enum (IDLE/RUN/DONE) and the constant MULT_CYCLES=32 in the shared package mips_pkg.
REQ-021 SHALL split out one sub-module, mult_shift_add, containing the accumulator, the multiplier shift register and the adder.
- The FSM, counter and sign handling stay in mult_unit_mips.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- op_a=3, op_b=5, start pulse -> stall=1 for 33 cycles (through RUN), done at cycle 33, hi=0x00000000, lo=0x0000000F.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT_SIGNED_EN defined, is_signed=1, 0xFFFFFFFE*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; same operands with MULT_SIGNED_EN undefined -> hi=0x00000002, lo=0xFFFFFFFA.
- start re-asserted with new operands at RUN cycle 5 -> ignored; single done at cycle 33 with the first result; the new start is accepted in the cycle after DONE.
- rst_n pulled low at RUN cycle 10 -> immediately busy=0, stall=0, hi=lo=0; no done pulse follows.
- op_a=0, op_b=0x12345678 -> still 33-cycle latency, hi=lo=0, and the previous hi/lo are visible until DONE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiplier FSM states and the default multiply length.
package mips_pkg;

  localparam int MULT_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Shift-add multiply datapath: multiplicand register, WIDTH+1 bit accumulator and
// multiplier shift register; product is {accumulator low WIDTH bits, multiplier}.
module mult_shift_add
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_CYCLES
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mpl_q;
  logic [WIDTH-1:0] mpl_d;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   sum_s;

  // The extra accumulator bit keeps the carry of the add until it is shifted down.
  always_comb begin
    sum_s = acc_q + (mpl_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    if (load_i) begin
      acc_d = {(WIDTH+1){1'b0}};
      mpl_d = mplier_i;
    end else if (step_i) begin
      acc_d = {1'b0, sum_s[WIDTH:1]};
      mpl_d = {sum_s[0], mpl_q[WIDTH-1:1]};
    end else begin
      acc_d = acc_q;
      mpl_d = mpl_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q <= {WIDTH{1'b0}};
      mpl_q   <= {WIDTH{1'b0}};
      acc_q   <= {(WIDTH+1){1'b0}};
    end else begin
      if (load_i) begin
        mcand_q <= mcand_i;
      end
      mpl_q <= mpl_d;
      acc_q <= acc_d;
    end
  end

  assign product_o = {acc_q[WIDTH-1:0], mpl_q};

endmodule

// File: rtl/mult_unit_mips.sv
// Iterative MIPS mult/multu unit: IDLE/RUN/DONE FSM driving a shift-add datapath.
// Define MULT_SIGNED_EN to honour is_signed (magnitude multiply plus final negate).
module mult_unit_mips
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             is_signed,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mult_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               load_s, step_s, busy_s, stall_s;
  logic [WIDTH-1:0]   mcand_s, mplier_s;
  logic [2*WIDTH-1:0] product_s, result_s;

  mult_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (load_s),
    .step_i    (step_s),
    .mcand_i   (mcand_s),
    .mplier_i  (mplier_s),
    .product_o (product_s)
  );

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic sign_a_s, sign_b_s;

  always_comb begin
    sign_a_s = is_signed & op_a[WIDTH-1];
    sign_b_s = is_signed & op_b[WIDTH-1];
    mcand_s  = sign_a_s ? (-op_a) : op_a;
    mplier_s = sign_b_s ? (-op_b) : op_b;
    neg_d    = load_s ? (sign_a_s ^ sign_b_s) : neg_q;
    result_s = neg_q ? (-product_s) : product_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`else
  logic unused_s;

  assign mcand_s  = op_a;
  assign mplier_s = op_b;
  assign result_s = product_s;
  assign unused_s = is_signed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RUN always lasts WIDTH steps; there is no early exit on zero operands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_s) begin
      cnt_d = {CW{1'b0}};
    end else if (step_s) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    load_s  = 1'b0;
    step_s  = 1'b0;
    busy_s  = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      IDLE: begin
        load_s  = start;
        stall_s = start & rst_n;
      end
      RUN: begin
        step_s  = 1'b1;
        busy_s  = 1'b1;
        stall_s = 1'b1;
      end
      DONE:    busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // hi/lo only change on leaving DONE, so the old result stays readable during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        {hi_q, lo_q} <= result_s;
      end
    end
  end

  assign busy  = busy_s;
  assign stall = stall_s;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_unit_mips.sv
// Directed scoreboard bench for mult_unit_mips: expected products are queued at
// issue and a negedge monitor compares them whenever done pulses.
module tb_mult_unit_mips;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        is_signed;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          failures = 0;
  int          done_pulses = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'h0;
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  mult_unit_mips dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .is_signed (is_signed),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=0x%0h required=no_done", {hi, lo});
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", {hi, lo}, mon_exp);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [63:0] exp, input int restart_at, input int rst_at);
    int k;
    int st_cnt;
    bit aborted;
    aborted = 1'b0;
    op_a = a;
    op_b = b;
    is_signed = sg;
    start = 1'b1;
    exp_q.push_back(exp);
    #1;
    st_cnt = (stall === 1'b1) ? 1 : 0;
    tick();
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      if (stall === 1'b1) st_cnt++;
      if (k == 10 && rst_at < 0) check("hold_during_run", {hi, lo}, last_res);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_stall", {63'h0, stall}, 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        void'(exp_q.pop_back());
        aborted = 1'b1;
        break;
      end
      start = (k == restart_at);
      if (k == restart_at) begin
        op_a = ~a;
        op_b = ~b;
      end
      tick();
      start = 1'b0;
      k++;
    end
    if (!aborted) begin
      check("latency", 64'(k), 64'd33);
      check("stall_cycles", 64'(st_cnt), 64'd33);
      check("busy_at_done", {63'h0, busy}, 64'h0);
      last_res = exp;
    end else begin
      last_res = 64'h0;
    end
  endtask

  initial begin
    logic [63:0] signed_exp;
`ifdef MULT_SIGNED_EN
    signed_exp = 64'hFFFFFFFF_FFFFFFFA;
`else
    signed_exp = 64'h00000002_FFFFFFFA;
`endif
    rst_n = 1'b0;
    start = 1'b1;
    op_a = 32'h0;
    op_b = 32'h0;
    is_signed = 1'b0;
    #12;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_stall", {63'h0, stall}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    run_op(32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, -1, -1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, -1, -1);
    run_op(32'hFFFFFFFE, 32'h00000003, 1'b1, signed_exp, -1, -1);
    run_op(32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, 5, -1);
    run_op(32'd7, 32'd9, 1'b0, 64'h00000000_0000003F, -1, -1);
    run_op(32'h0, 32'h12345678, 1'b0, 64'h0, -1, -1);
    run_op(32'h80000000, 32'd4, 1'b0, 64'h00000002_00000000, -1, -1);

    run_op(32'd5, 32'd5, 1'b0, 64'h19, -1, 10);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("post_reset_hilo", {hi, lo}, 64'h0);
    check("post_reset_busy", {63'h0, busy}, 64'h0);

    run_op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000_FFFE0001, -1, -1);
    tick();
    tick();
    check("done_pulses", 64'(done_pulses), 64'd8);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
